// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS
// pipeline. Holds the PC, fetches from instruction memory with at most one
// request outstanding, applies the hazard-unit controls (pc_write,
// IF_ID_write, flush), and counts the cycles in which fetch could not deliver.
//
// Memory handshake: imem_req is the request valid and imem_addr the request
// payload. imem_ready is the completion strobe: imem_rdata is valid for
// imem_addr in exactly the cycle imem_ready=1. While imem_req=1 and
// imem_ready=0 the address is held stable. The one exception is a redirect
// in FETCH, which moves to SQUASH and keeps presenting the abandoned address.
// imem_req drops during rst, and the memory must tolerate this.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write,
  input  logic             IF_ID_write,
  input  logic             flush,
  input  logic [1:0]       pc_src,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      jump_target,
  input  logic [31:0]      jr_target,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      IF_ID_inst,
  output logic [31:0]      IF_ID_pc_plus4,
  output logic             IF_ID_valid,
  output logic             fetch_stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             fsm_state_dbg   // 0 = FETCH, 1 = SQUASH
);

  typedef enum logic {
    ST_FETCH  = 1'b0,
    ST_SQUASH = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        squash_addr_q, squash_addr_d;
  logic [31:0]        inst_q, inst_d;
  logic [31:0]        pc_plus4_q, pc_plus4_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [31:0]        pc_plus4;
  logic [31:0]        redirect_target;
  logic               accept;
  logic               redirect;

  assign pc_plus4 = pc_q + 32'd4;
  assign accept   = (state_q == ST_FETCH) & imem_ready & pc_write & IF_ID_write & ~flush;
  // A flush while the PC is frozen is dropped. The branch stays in ID and
  // asks again next cycle.
  assign redirect = flush & pc_write;

  // Redirect target selection. The low two bits are forced to 00 so the
  // fetch address stays word aligned.
  always_comb begin
    redirect_target = pc_q;
    case (pc_src)
      2'b00:   redirect_target = pc_q;
      2'b01:   redirect_target = branch_target;
      2'b10:   redirect_target = jump_target;
      default: redirect_target = jr_target;
    endcase
    redirect_target[1:0] = 2'b00;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  // FSM next state. A redirect that leaves a request pending must wait for
  // that request to complete. The reply is then discarded in SQUASH.
  always_comb begin
    state_d       = state_q;
    squash_addr_d = squash_addr_q;
    case (state_q)
      ST_FETCH: begin
        if (redirect && !imem_ready) begin
          state_d       = ST_SQUASH;
          squash_addr_d = pc_q;
        end
      end
      ST_SQUASH: begin
        if (imem_ready) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // FSM outputs: memory request, address and the fetch-stall flag.
  always_comb begin
    imem_req    = ~rst;
    imem_addr   = (state_q == ST_SQUASH) ? squash_addr_q : pc_q;
    fetch_stall = ~rst & (((state_q == ST_FETCH) & ~imem_ready) | (state_q == ST_SQUASH));
  end

  // PC, IF/ID and stall-counter next-state values, in hazard-priority order.
  always_comb begin
    pc_d = pc_q;
    if (pc_write) begin
      if (redirect)    pc_d = redirect_target;
      else if (accept) pc_d = pc_plus4;
    end

    inst_d     = inst_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (IF_ID_write) begin
      pc_plus4_d = pc_plus4;
      if (!redirect && accept) begin
        inst_d  = imem_rdata;
        valid_d = 1'b1;
      end else begin
        inst_d  = NOP_INST;
        valid_d = 1'b0;
      end
    end

    cnt_d = cnt_q;
    if (fetch_stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  // Datapath registers: PC, squash address, IF/ID and the stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      squash_addr_q <= RESET_PC;
      inst_q        <= NOP_INST;
      pc_plus4_q    <= RESET_PC;
      valid_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      pc_q          <= pc_d;
      squash_addr_q <= squash_addr_d;
      inst_q        <= inst_d;
      pc_plus4_q    <= pc_plus4_d;
      valid_q       <= valid_d;
      cnt_q         <= cnt_d;
    end
  end

  assign IF_ID_inst     = inst_q;
  assign IF_ID_pc_plus4 = pc_plus4_q;
  assign IF_ID_valid    = valid_q;
  assign stall_cnt      = cnt_q;
  assign fsm_state_dbg  = state_q;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline.
- Holds the PC and fetches from instruction memory over a ready handshake, one request outstanding at a time.
- Applies the hazard-unit controls: pc_write, IF_ID_write and flush; the redirect target comes from the ID-stage next-PC selection.
- Feeds IF_ID_inst and IF_ID_pc_plus4 to ID and the data hazard detection unit; counts fetch stall cycles.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0000, instruction inserted into IF/ID as a bubble
CNT_W, 16, width of the saturating stall counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
pc_write  in  1  0 = hold PC (load-use stall)
IF_ID_write  in  1  0 = hold IF/ID contents
flush  in  1  redirect fetch and bubble IF/ID
pc_src  in  2  redirect target: 00 current PC (refetch), 01 branch_target, 10 jump_target, 11 jr_target
branch_target  in  32  branch target computed in ID
jump_target  in  32  jump target computed in ID
jr_target  in  32  register target for jr
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, word aligned
imem_ready  in  1  imem_rdata valid for imem_addr this cycle
imem_rdata  in  32  fetched instruction
IF_ID_inst  out  32  instruction to ID
IF_ID_pc_plus4  out  32  PC+4 of that instruction
IF_ID_valid  out  1  1 = real instruction, 0 = bubble
fetch_stall  out  1  fetch could not deliver this cycle
stall_cnt  out  CNT_W  saturating count of fetch_stall cycles

Behaviour:
- Reset (sync, rst=1 at edge):
  - PC=RESET_PC; state=FETCH.
  - IF_ID_inst=NOP_INST, IF_ID_pc_plus4=RESET_PC, IF_ID_valid=0; stall_cnt=0.
  - During rst, imem_req=0.
- Reset mid-operation: any SQUASH state or outstanding request is abandoned; memory must tolerate imem_req dropping.
- FSM states:
  - FETCH: imem_req=1, imem_addr=PC.
  - SQUASH: imem_req=1, imem_addr=squash_addr; waits out an abandoned request.
- accept = (state==FETCH) & imem_ready & pc_write & IF_ID_write & ~flush.
- redirect = flush & pc_write.
- flush with pc_write=0 is ignored that cycle; the stalled branch stays in ID and is re-evaluated next cycle.
- PC update, in priority order:
  - rst
  - pc_write=0: hold
  - redirect: PC <= target selected by pc_src, with bits [1:0] forced to 00
  - accept: PC <= PC+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0)
  - otherwise: hold
- IF/ID update, in priority order:
  - rst
  - IF_ID_write=0: hold all three fields
  - redirect: NOP_INST, valid=0, pc_plus4 <= PC+4
  - accept: imem_rdata, PC+4, valid=1
  - otherwise: NOP_INST, valid=0 (bubble; pc_plus4 <= PC+4)
- Transitions:
  - FETCH -> SQUASH: on redirect while imem_ready=0; squash_addr <= old PC.
  - FETCH, redirect with imem_ready=1: response is discarded; stay in FETCH.
  - SQUASH -> FETCH: on imem_ready=1; response discarded, no IF/ID load.
  - SQUASH + redirect: PC updates; stay in SQUASH; squash_addr unchanged.
- Stall outputs:
  - fetch_stall = ~rst & ((state==FETCH & ~imem_ready) | state==SQUASH).
  - stall_cnt increments when fetch_stall=1 and saturates at all-ones.
- Latency: instruction at PC appears on IF_ID outputs the edge after the imem_ready cycle.
- Throughput: one instruction per cycle when memory is ready every cycle.
- imem_addr must stay stable while imem_req=1 and imem_ready=0, unless a redirect moves FETCH to SQUASH (the squashed address is then held).

Test Plan:
- Reset release, imem_ready=1 constant, rdata=0x20080001,0x20090002,... -> imem_addr 0,4,8; IF_ID_inst follows one cycle later; IF_ID_pc_plus4=4,8; valid=1; stall_cnt=0.
- pc_write=0, IF_ID_write=0 for 2 cycles at PC=0x10 -> PC stays 0x10; IF_ID held; flush=1 in the same cycles is ignored.
- flush=1, pc_src=01, branch_target=0x40, imem_ready=1 at PC=0x0C -> next PC=0x40; IF_ID_valid=0 with NOP_INST; next fetch at 0x40.
- imem_ready=0 at PC=0x08, flush with pc_src=10, jump_target=0x100 -> SQUASH: imem_addr stays 0x08 until ready. The 0x08 data is never loaded into IF/ID. Then imem_addr=0x100; fetch_stall=1 throughout; stall_cnt counts the cycles.
- pc_src=11, jr_target=0x203 -> PC=0x200. Separately, from PC=0xFFFF_FFFC with accept -> PC=0.
- stall_cnt preloaded near saturation (CNT_W=4, 20 stall cycles) -> holds 4'hF; rst asserted in SQUASH -> state FETCH, PC=RESET_PC, all outputs at reset values next cycle.
